uniregister_seq: RTL and testbench



---
 rtl/uniregister_seq.sv | 98 +++++++++
 tb/tb_uniregister_seq.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/uniregister_seq.sv
// WIDTH-bit universal register (hold/load/shift/rotate/ashr/clear) with a
// sequenced multi-shift mode: one start request performs n shifts back to back.
module uniregister_seq #(
   parameter int WIDTH = 8,
   parameter int CW    = 4
) (
   input  logic             c,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   input  logic             i,
   input  logic [2:0]       op,
   input  logic [CW-1:0]    n,
   input  logic             start,
   output logic [WIDTH-1:0] q,
   output logic             so_l,
   output logic             so_r,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

   state_t           state, state_nx;
   logic [WIDTH-1:0] q_nx;
   logic [2:0]       op_l, op_l_nx;
   logic [CW-1:0]    cnt, cnt_nx;

   function automatic logic is_shift(input logic [2:0] o);
      return (o >= 3'b010) && (o <= 3'b110);
   endfunction

   function automatic logic [WIDTH-1:0] apply_op(input logic [2:0]       o,
                                                 input logic [WIDTH-1:0] qv,
                                                 input logic [WIDTH-1:0] dv,
                                                 input logic             iv);
      logic [WIDTH-1:0] r;
      case (o)
         3'b000:  r = qv;
         3'b001:  r = dv;
         3'b010:  r = {qv[WIDTH-2:0], iv};
         3'b011:  r = {iv, qv[WIDTH-1:1]};
         3'b100:  r = {qv[WIDTH-2:0], qv[WIDTH-1]};
         3'b101:  r = {qv[0], qv[WIDTH-1:1]};
         3'b110:  r = {qv[WIDTH-1], qv[WIDTH-1:1]};
         default: r = '0;
      endcase
      return r;
   endfunction

   always_comb begin
      state_nx = state;
      q_nx     = q;
      op_l_nx  = op_l;
      cnt_nx   = cnt;
      case (state)
         IDLE: begin
            if (start && is_shift(op)) begin
               // the start edge only captures the request; q moves from the next edge
               op_l_nx  = op;
               cnt_nx   = n;
               state_nx = (n == '0) ? DONE : BUSY;
            end else begin
               q_nx = apply_op(op, q, d, i);
            end
         end
         BUSY: begin
            q_nx   = apply_op(op_l, q, d, i);
            cnt_nx = cnt - CW'(1);
            if (cnt <= CW'(1)) begin
               cnt_nx   = '0;
               state_nx = DONE;
            end
         end
         DONE: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge c) begin
      if (rst) begin
         state <= IDLE;
         q     <= '0;
         op_l  <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         q     <= q_nx;
         op_l  <= op_l_nx;
         cnt   <= cnt_nx;
      end
   end

   assign so_l = q[WIDTH-1];
   assign so_r = q[0];
   assign busy = (state == BUSY);
   assign done = (state == DONE);

endmodule

// File: tb/tb_uniregister_seq.sv
// Bench for uniregister_seq: directed scenarios plus random traffic, every
// cycle compared against a queue-based reference model.
module tb_uniregister_seq;
   localparam int W  = 8;
   localparam int CW = 4;
   localparam int TOK_DONE = -1;

   logic          c = 1'b0;
   logic          rst, i, start;
   logic [W-1:0]  d;
   logic [2:0]    op;
   logic [CW-1:0] n;
   logic [W-1:0]  q;
   logic          so_l, so_r, busy, done;

   uniregister_seq #(.WIDTH(W), .CW(CW)) dut (
      .c(c), .rst(rst), .d(d), .i(i), .op(op), .n(n), .start(start),
      .q(q), .so_l(so_l), .so_r(so_r), .busy(busy), .done(done)
   );

   always #5 c = ~c;

   int nchk  = 0;
   int npass = 0;
   int mq    = 0;
   int pend[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nchk++;
      if (got === exp) npass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic int apply(input int o, input int qv, input int iv, input int dv);
      int mask, msb;
      mask = (1 << W) - 1;
      msb  = 1 << (W - 1);
      case (o)
         0: return qv;
         1: return dv;
         2: return ((qv << 1) | iv) & mask;
         3: return (qv >> 1) | (iv * msb);
         4: return ((qv << 1) | (qv >> (W - 1))) & mask;
         5: return (qv >> 1) | ((qv & 1) * msb);
         6: return (qv >> 1) | (qv & msb);
         default: return 0;
      endcase
   endfunction

   // A request becomes n queued shift ops followed by a done token.
   task automatic model_edge();
      int t;
      if (rst) begin
         pend.delete();
         mq = 0;
      end else if (pend.size() > 0) begin
         t = pend.pop_front();
         if (t != TOK_DONE) mq = apply(t, mq, int'(i), int'(d));
      end else if (start && op >= 3'd2 && op <= 3'd6) begin
         repeat (int'(n)) pend.push_back(int'(op));
         pend.push_back(TOK_DONE);
      end else begin
         mq = apply(int'(op), mq, int'(i), int'(d));
      end
   endtask

   function automatic logic exp_busy();
      return (pend.size() > 0) && (pend[0] != TOK_DONE);
   endfunction

   function automatic logic exp_done();
      return (pend.size() > 0) && (pend[0] == TOK_DONE);
   endfunction

   task automatic step(input string tag);
      @(posedge c);
      model_edge();
      #1;
      chk({tag, ".q"},    32'(q),    32'(mq));
      chk({tag, ".busy"}, 32'(busy), 32'(exp_busy()));
      chk({tag, ".done"}, 32'(done), 32'(exp_done()));
      chk({tag, ".so_l"}, 32'(so_l), 32'((mq >> (W - 1)) & 1));
      chk({tag, ".so_r"}, 32'(so_r), 32'(mq & 1));
   endtask

   task automatic drive(input logic r, input logic [2:0] o, input logic [W-1:0] dv,
                        input logic iv, input logic s, input logic [CW-1:0] nv);
      rst = r; op = o; d = dv; i = iv; start = s; n = nv;
   endtask

   int dones;

   initial begin
      drive(1'b1, 3'd0, 8'h00, 1'b0, 1'b0, 4'd0);
      step("init");

      // reset wins over a start request
      drive(1'b0, 3'd1, 8'hFF, 1'b0, 1'b0, 4'd0); step("ldff");
      drive(1'b1, 3'd2, 8'hFF, 1'b1, 1'b1, 4'd3); step("rst");
      chk("rst.q_const", 32'(q), 32'h00);
      drive(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 4'd0); step("rst.after");
      chk("rst.busy_const", 32'(busy), 32'd0);

      // single-cycle operations
      drive(1'b0, 3'd1, 8'hA5, 1'b0, 1'b0, 4'd0); step("ld");  chk("ld_const", 32'(q), 32'hA5);
      drive(1'b0, 3'd3, 8'h00, 1'b1, 1'b0, 4'd0); step("shr"); chk("shr_const", 32'(q), 32'hD2);
      drive(1'b0, 3'd1, 8'hA5, 1'b0, 1'b0, 4'd0); step("ld2");
      drive(1'b0, 3'd2, 8'h00, 1'b0, 1'b0, 4'd0); step("shl"); chk("shl_const", 32'(q), 32'h4A);
      drive(1'b0, 3'd1, 8'h80, 1'b1, 1'b0, 4'd0); step("ld3");
      drive(1'b0, 3'd6, 8'h00, 1'b0, 1'b0, 4'd0); step("ashr"); chk("ashr_const", 32'(q), 32'hC0);
      drive(1'b0, 3'd1, 8'h01, 1'b0, 1'b0, 4'd0); step("ld4");
      drive(1'b0, 3'd5, 8'h00, 1'b0, 1'b0, 4'd0); step("rotr"); chk("rotr_const", 32'(q), 32'h80);
      drive(1'b0, 3'd7, 8'h00, 1'b0, 1'b0, 4'd0); step("clr"); chk("clr_const", 32'(q), 32'h00);
      drive(1'b0, 3'd1, 8'h3C, 1'b0, 1'b0, 4'd0); step("ld5");
      drive(1'b0, 3'd0, 8'hFF, 1'b1, 1'b0, 4'd0);
      repeat (3) step("hold");
      chk("hold_const", 32'(q), 32'h3C);

      // sequenced rotl by 3
      drive(1'b0, 3'd1, 8'h81, 1'b0, 1'b0, 4'd0); step("ld81");
      drive(1'b0, 3'd4, 8'h00, 1'b0, 1'b1, 4'd3); step("rotl.e0");
      chk("rotl.e0_q", 32'(q), 32'h81);
      chk("rotl.e0_busy", 32'(busy), 32'd1);
      drive(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 4'd0);
      step("rotl.e1"); chk("rotl.e1_q", 32'(q), 32'h03);
      step("rotl.e2"); chk("rotl.e2_q", 32'(q), 32'h06);
      step("rotl.e3"); chk("rotl.e3_q", 32'(q), 32'h0C);
      chk("rotl.e3_done", 32'(done), 32'd1);
      step("rotl.e4"); chk("rotl.e4_q", 32'(q), 32'h0C);

      // inputs ignored while busy; new start accepted right after done
      drive(1'b0, 3'd7, 8'h00, 1'b0, 1'b0, 4'd0); step("clr2");
      drive(1'b0, 3'd2, 8'h00, 1'b1, 1'b1, 4'd4); step("ign.e0");
      drive(1'b0, 3'd1, 8'h55, 1'b1, 1'b1, 4'd9);
      dones = 0;
      step("ign.e1"); chk("ign.e1_q", 32'(q), 32'h01); dones += int'(done);
      step("ign.e2"); chk("ign.e2_q", 32'(q), 32'h03); dones += int'(done);
      step("ign.e3"); chk("ign.e3_q", 32'(q), 32'h07); dones += int'(done);
      step("ign.e4"); chk("ign.e4_q", 32'(q), 32'h0F); dones += int'(done);
      drive(1'b0, 3'd2, 8'h55, 1'b0, 1'b1, 4'd1);
      step("ign.dn"); dones += int'(done);
      chk("ign.one_done", 32'(dones), 32'd1);
      chk("ign.dn_q", 32'(q), 32'h0F);
      step("ign.re0"); chk("ign.re0_busy", 32'(busy), 32'd1);
      drive(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 4'd0);
      step("ign.re1"); chk("ign.re1_q", 32'(q), 32'h1E);
      step("ign.re2");

      // abort mid-sequence via reset
      drive(1'b0, 3'd1, 8'hF0, 1'b0, 1'b0, 4'd0); step("ldf0");
      drive(1'b0, 3'd3, 8'h00, 1'b0, 1'b1, 4'd5); step("abt.e0");
      drive(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 4'd0);
      step("abt.e1");
      step("abt.e2"); chk("abt.e2_q", 32'(q), 32'h3C);
      drive(1'b1, 3'd0, 8'h00, 1'b0, 1'b0, 4'd0); step("abt.rst");
      drive(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 4'd0);
      dones = 0;
      repeat (6) begin step("abt.post"); dones += int'(done); end
      chk("abt.no_done", 32'(dones), 32'd0);

      // zero count
      drive(1'b0, 3'd1, 8'h5A, 1'b0, 1'b0, 4'd0); step("ld5a");
      drive(1'b0, 3'd4, 8'h00, 1'b0, 1'b1, 4'd0); step("zero.e0");
      chk("zero.done", 32'(done), 32'd1);
      chk("zero.busy", 32'(busy), 32'd0);
      drive(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 4'd0); step("zero.e1");
      chk("zero.q", 32'(q), 32'h5A);
      chk("zero.done_end", 32'(done), 32'd0);

      // random traffic
      for (int k = 0; k < 500; k++) begin
         drive(($urandom_range(0, 49) == 0), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
               1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)));
         step("rnd");
      end

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end
endmodule
